// File: rtl/sprite_seq_pkg.sv
// Shared types and screen constants for the sprite move sequencer.
package sprite_seq_pkg;

   localparam int unsigned ScreenW = 160;
   localparam int unsigned ScreenH = 120;

   typedef enum logic [2:0] {
      StIdle,
      StClear,
      StUpdate,
      StLoad,
      StPaint
   } state_e;

   typedef enum logic [1:0] {
      DirUp    = 2'd0,
      DirDown  = 2'd1,
      DirLeft  = 2'd2,
      DirRight = 2'd3
   } dir_e;

endpackage

// File: rtl/frame_tick_gen.sv
// Free-running movement tick: one-cycle pulse every FRAME_DIV clocks.
module frame_tick_gen #(
   parameter int unsigned FRAME_DIV = 833333
) (
   input  logic clk,
   input  logic resetn,
   output logic tick
);

   localparam int unsigned CntW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(FRAME_DIV - 1);

   logic [CntW-1:0] cnt_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q <= '0;
      end else if (cnt_q == CntMax) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CntW'(1);
      end
   end

   assign tick = (cnt_q == CntMax);

endmodule

// File: rtl/sprite_move_sequencer.sv
// Erase / move / repaint sequencer driving a sprite engine once per frame tick.
// Optional watchdog on engine handshakes: define SPRITE_SEQ_WATCHDOG_EN.
module sprite_move_sequencer
   import sprite_seq_pkg::*;
#(
   parameter int unsigned FRAME_DIV = 833333,
   parameter int unsigned STEP      = 1,
   parameter int unsigned X_MAX     = ScreenW - 1,
   parameter int unsigned Y_MAX     = ScreenH - 1,
   parameter int unsigned SPR_W     = 16,
   parameter int unsigned SPR_H     = 16,
   parameter int unsigned START_X   = 49,
   parameter int unsigned START_Y   = 48
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       dir_up,
   input  logic       dir_down,
   input  logic       dir_left,
   input  logic       dir_right,
   input  logic       sprite_complete,
   output logic       draw,
   output logic       clear,
   output logic       shift_h,
   output logic       shift_v,
   output logic       load,
   output logic [6:0] shift_amount,
   output logic [7:0] load_x,
   output logic [6:0] load_y,
   output logic [7:0] pos_x,
   output logic [6:0] pos_y,
   output logic       busy,
   output logic       seq_error
);

   localparam logic [8:0] StepX = 9'(STEP);
   localparam logic [8:0] LimX  = 9'(X_MAX - SPR_W + 1);
   localparam logic [7:0] StepY = 8'(STEP);
   localparam logic [7:0] LimY  = 8'(Y_MAX - SPR_H + 1);

   state_e     state_q;
   dir_e       dir_q, req_dir;
   logic       seen_low_q, pass_done, any_dir, tick;
   logic [7:0] pos_x_q, new_x;
   logic [6:0] pos_y_q, new_y;
   logic [8:0] sum_x;
   logic [7:0] sum_y;
   logic       draw_q, clear_q, shift_h_q, shift_v_q, load_q;

   frame_tick_gen #(
      .FRAME_DIV(FRAME_DIV)
   ) u_tick (
      .clk   (clk),
      .resetn(resetn),
      .tick  (tick)
   );

   assign any_dir   = dir_up | dir_down | dir_left | dir_right;
   assign pass_done = seen_low_q & sprite_complete;

   always_comb begin
      req_dir = DirRight;
      if (dir_up)         req_dir = DirUp;
      else if (dir_down)  req_dir = DirDown;
      else if (dir_left)  req_dir = DirLeft;
   end

   // One extra bit exposes underflow (bit 8/7 set on decrement) before clamping.
   always_comb begin
      sum_x = {1'b0, pos_x_q};
      sum_y = {1'b0, pos_y_q};
      unique case (dir_q)
         DirUp:    sum_y = {1'b0, pos_y_q} - StepY;
         DirDown:  sum_y = {1'b0, pos_y_q} + StepY;
         DirLeft:  sum_x = {1'b0, pos_x_q} - StepX;
         DirRight: sum_x = {1'b0, pos_x_q} + StepX;
      endcase
      if (dir_q == DirLeft && sum_x[8]) new_x = '0;
      else if (sum_x > LimX)            new_x = LimX[7:0];
      else                              new_x = sum_x[7:0];
      if (dir_q == DirUp && sum_y[7])   new_y = '0;
      else if (sum_y > LimY)            new_y = LimY[6:0];
      else                              new_y = sum_y[6:0];
   end

`ifdef SPRITE_SEQ_WATCHDOG_EN
   logic [9:0] wd_q;
   logic       err_q;
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= StIdle;
         dir_q      <= DirUp;
         seen_low_q <= 1'b0;
         pos_x_q    <= 8'(START_X);
         pos_y_q    <= 7'(START_Y);
         draw_q     <= 1'b0;
         clear_q    <= 1'b0;
         shift_h_q  <= 1'b0;
         shift_v_q  <= 1'b0;
         load_q     <= 1'b0;
`ifdef SPRITE_SEQ_WATCHDOG_EN
         wd_q       <= '0;
         err_q      <= 1'b0;
`endif
      end else begin
         load_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (tick && any_dir) begin
                  dir_q      <= req_dir;
                  state_q    <= StClear;
                  draw_q     <= 1'b1;
                  clear_q    <= 1'b1;
                  seen_low_q <= 1'b0;
               end
            end
            StClear: begin
               if (pass_done) begin
                  state_q <= StUpdate;
                  draw_q  <= 1'b0;
                  clear_q <= 1'b0;
               end else if (!sprite_complete) begin
                  seen_low_q <= 1'b1;
               end
            end
            StUpdate: begin
               pos_x_q <= new_x;
               pos_y_q <= new_y;
               load_q  <= 1'b1;
               state_q <= StLoad;
            end
            StLoad: begin
               state_q    <= StPaint;
               draw_q     <= 1'b1;
               shift_h_q  <= (dir_q == DirLeft) || (dir_q == DirRight);
               shift_v_q  <= (dir_q == DirUp) || (dir_q == DirDown);
               seen_low_q <= 1'b0;
            end
            StPaint: begin
               if (pass_done) begin
                  state_q   <= StIdle;
                  draw_q    <= 1'b0;
                  shift_h_q <= 1'b0;
                  shift_v_q <= 1'b0;
               end else if (!sprite_complete) begin
                  seen_low_q <= 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
`ifdef SPRITE_SEQ_WATCHDOG_EN
         // Abort a pass the engine never finishes; overrides the case above.
         if (state_q == StClear || state_q == StPaint) begin
            wd_q <= wd_q + 10'd1;
            if (wd_q == 10'd1023 && !pass_done) begin
               state_q   <= StIdle;
               draw_q    <= 1'b0;
               clear_q   <= 1'b0;
               shift_h_q <= 1'b0;
               shift_v_q <= 1'b0;
               err_q     <= 1'b1;
            end
         end else begin
            wd_q <= '0;
         end
`endif
      end
   end

`ifdef SPRITE_SEQ_WATCHDOG_EN
   assign seq_error = err_q;
`else
   assign seq_error = 1'b0;
`endif

   assign draw         = draw_q;
   assign clear        = clear_q;
   assign shift_h      = shift_h_q;
   assign shift_v      = shift_v_q;
   assign load         = load_q;
   assign shift_amount = 7'(STEP);
   assign load_x       = pos_x_q;
   assign load_y       = pos_y_q;
   assign pos_x        = pos_x_q;
   assign pos_y        = pos_y_q;
   assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_sprite_move_sequencer.sv
// Scoreboard bench: directed moves push expected loads; a monitor checks each load/paint.
module tb_sprite_move_sequencer;

   logic       clk = 1'b0;
   logic       resetn;
   logic       dir_up, dir_down, dir_left, dir_right;
   logic       sprite_complete = 1'b1;
   logic       draw, clear, shift_h, shift_v, load, busy, seq_error;
   logic [6:0] shift_amount;
   logic [7:0] load_x, pos_x;
   logic [6:0] load_y, pos_y;

   always #5 clk = ~clk;

   sprite_move_sequencer #(
      .FRAME_DIV(8)
   ) dut (
      .clk            (clk),
      .resetn         (resetn),
      .dir_up         (dir_up),
      .dir_down       (dir_down),
      .dir_left       (dir_left),
      .dir_right      (dir_right),
      .sprite_complete(sprite_complete),
      .draw           (draw),
      .clear          (clear),
      .shift_h        (shift_h),
      .shift_v        (shift_v),
      .load           (load),
      .shift_amount   (shift_amount),
      .load_x         (load_x),
      .load_y         (load_y),
      .pos_x          (pos_x),
      .pos_y          (pos_y),
      .busy           (busy),
      .seq_error      (seq_error)
   );

   typedef struct packed {
      logic [7:0] x;
      logic [6:0] y;
      logic       h;
   } exp_t;

   exp_t exp_q[$];
   exp_t cur_exp;
   int   n_checks = 0;
   int   n_pass   = 0;

   function automatic void chk(string name, int act, int req);
      n_checks++;
      if (act == req) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, req);
   endfunction

   // Engine model: drops sprite_complete when draw rises, raises it 5 cycles later.
   logic eng_draw_q = 1'b0;
   int   eng_cnt    = 0;
   logic stuck      = 1'b0;

   always @(posedge clk) begin
      eng_draw_q <= draw;
      if (draw && !eng_draw_q) begin
         sprite_complete <= 1'b0;
         eng_cnt         <= 5;
      end else if (eng_cnt != 0) begin
         eng_cnt <= eng_cnt - 1;
         if (eng_cnt == 1 && !stuck) sprite_complete <= 1'b1;
      end
   end

   logic mon_draw_q = 1'b0;

   always @(negedge clk) begin
      exp_t e;
      if (resetn) begin
         if (load) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_load", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("load_x", int'(load_x), int'(e.x));
               chk("load_y", int'(load_y), int'(e.y));
               chk("pos_x", int'(pos_x), int'(e.x));
               chk("pos_y", int'(pos_y), int'(e.y));
               cur_exp <= e;
            end
         end
         if (draw && !mon_draw_q) begin
            if (clear) begin
               chk("clear_pass_shifts", int'({shift_h, shift_v}), 0);
            end else begin
               chk("paint_shift_h", int'(shift_h), int'(cur_exp.h));
               chk("paint_shift_v", int'(shift_v), int'(!cur_exp.h));
            end
         end
      end
      mon_draw_q <= draw;
   end

   task automatic wait_busy(input logic level, input int budget, input string name);
      int n = 0;
      while (busy !== level && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(name, int'(busy), int'(level));
   endtask

   task automatic do_move(input logic u, input logic d, input logic l, input logic r,
                          input logic [7:0] ex, input logic [6:0] ey, input logic h,
                          input logic hold);
      exp_t e;
      e.x = ex;
      e.y = ey;
      e.h = h;
      exp_q.push_back(e);
      dir_up    = u;
      dir_down  = d;
      dir_left  = l;
      dir_right = r;
      wait_busy(1'b1, 40, "seq_start");
      if (!hold) {dir_up, dir_down, dir_left, dir_right} = 4'b0;
      wait_busy(1'b0, 200, "seq_end");
      {dir_up, dir_down, dir_left, dir_right} = 4'b0;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_draw"}, int'(draw), 0);
      chk({tag, "_clear"}, int'(clear), 0);
      chk({tag, "_shifts"}, int'({shift_h, shift_v}), 0);
      chk({tag, "_load"}, int'(load), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_seq_error"}, int'(seq_error), 0);
      chk({tag, "_pos_x"}, int'(pos_x), 49);
      chk({tag, "_pos_y"}, int'(pos_y), 48);
      chk({tag, "_load_x"}, int'(load_x), 49);
      chk({tag, "_load_y"}, int'(load_y), 48);
   endtask

   initial begin
      int n;
      resetn = 1'b0;
      {dir_up, dir_down, dir_left, dir_right} = 4'b0;
      repeat (3) @(negedge clk);
      chk_reset_state("reset");
      chk("shift_amount", int'(shift_amount), 1);
      resetn = 1'b1;
      @(negedge clk);

      do_move(1'b0, 1'b0, 1'b0, 1'b1, 8'd50, 7'd48, 1'b1, 1'b0);
      // Up beats left: only y changes, vertical paint.
      do_move(1'b1, 1'b0, 1'b1, 1'b0, 8'd50, 7'd47, 1'b0, 1'b0);
      // Direction held through the whole sequence: ticks while busy must be dropped.
      do_move(1'b0, 1'b1, 1'b0, 1'b0, 8'd50, 7'd48, 1'b0, 1'b1);

      for (int i = 51; i <= 144; i++) do_move(1'b0, 1'b0, 1'b0, 1'b1, 8'(i), 7'd48, 1'b1, 1'b0);
      do_move(1'b0, 1'b0, 1'b0, 1'b1, 8'd144, 7'd48, 1'b1, 1'b0);
      for (int i = 47; i >= 0; i--) do_move(1'b1, 1'b0, 1'b0, 1'b0, 8'd144, 7'(i), 1'b0, 1'b0);
      do_move(1'b1, 1'b0, 1'b0, 1'b0, 8'd144, 7'd0, 1'b0, 1'b0);

      // Reset in the middle of the paint pass.
      begin
         exp_t e;
         e.x = 8'd143;
         e.y = 7'd0;
         e.h = 1'b1;
         exp_q.push_back(e);
      end
      dir_left = 1'b1;
      wait_busy(1'b1, 40, "mid_paint_start");
      dir_left = 1'b0;
      n = 0;
      while (!(draw && shift_h) && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk("reached_paint", int'(draw && shift_h), 1);
      resetn = 1'b0;
      #1;
      chk_reset_state("mid_paint_reset");
      @(negedge clk);
      resetn = 1'b1;
      repeat (40) @(negedge clk);
      chk("queue_after_reset", exp_q.size(), 0);

      // Engine never finishes the erase pass.
      stuck     = 1'b1;
      dir_right = 1'b1;
      wait_busy(1'b1, 40, "stuck_start");
      dir_right = 1'b0;
      repeat (1100) @(negedge clk);
`ifdef SPRITE_SEQ_WATCHDOG_EN
      chk("wd_busy", int'(busy), 0);
      chk("wd_draw", int'(draw), 0);
      chk("wd_seq_error", int'(seq_error), 1);
      repeat (20) @(negedge clk);
      chk("wd_seq_error_sticky", int'(seq_error), 1);
`else
      chk("stuck_busy", int'(busy), 1);
      chk("stuck_clear", int'(clear), 1);
      chk("stuck_draw", int'(draw), 1);
      chk("stuck_seq_error", int'(seq_error), 0);
`endif
      resetn = 1'b0;
      stuck  = 1'b0;
      #1;
      chk("final_reset_seq_error", int'(seq_error), 0);
      chk("final_reset_busy", int'(busy), 0);
      @(negedge clk);
      resetn = 1'b1;
      repeat (5) @(negedge clk);
      chk("queue_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
